fp_norm_round: RTL
==================

Name: fp_norm_round

Overview:
- Post-normalizer and rounder for the FP32 adder datapath. Consumes the adder's pre-normalized triple {sign, signed biased exponent, 48-bit mantissa} and returns a packed IEEE-754 binary32 result with status flags.
- Two-stage elastic pipeline with valid/ready handshakes on both sides. Sits directly downstream of the adder in the accumulation path.

Parameters:
C_EXP, 8, exponent width (fp_defs::C_EXP)
C_MANT, 23, stored fraction width (fp_defs::C_MANT)
C_EXP_PRENORM, 10, signed prenorm exponent width (fp_defs::C_EXP_PRENORM)
C_MANT_PRENORM, 48, prenorm mantissa width (fp_defs::C_MANT_PRENORM)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
in_valid_i  in  1  prenorm triple valid
in_ready_o  out  1  block accepts triple
sign_prenorm_i  in  1  result sign from adder
exp_prenorm_i  in  C_EXP_PRENORM  signed biased exponent of larger operand
mant_prenorm_i  in  C_MANT_PRENORM  bit47 carry, bit46 hidden, 45:23 fraction, 22 guard, 21 round, 20 sticky, 19:0 zero
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
result_o  out  32  packed binary32
overflow_o  out  1  result rounded to infinity
inexact_o  out  1  precision lost or overflow

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: all stage-valid bits 0; out_valid_o 0; result_o 0; flags 0. Reset mid-operation discards both stages; out_valid_o is 0 the cycle after rst_i is sampled high.
- Handshake: a transfer occurs when valid && ready on the same edge. Each stage advances when its downstream is empty or being drained.
  - in_ready_o = !s1_valid || (!s2_valid || out_ready_i).
  - out_valid_o is held, and result_o/flags are held stable, until out_ready_i.
  - Throughput is 1 per cycle. Latency is 2 cycles from accept to out_valid_o, with no bubbles under continuous out_ready_i.
- Stage 1 (normalize, registered):
  - mant == 0: zero path. Result forced to +0, flags 0.
  - bit47 set: shift right by 1, exp+1. The shifted-out bit is ORed into sticky.
  - Else: lz = leading zeros counted from bit46.
    - If exp - lz >= 1: shift left by lz, exp -= lz.
    - Otherwise (subnormal): shift left by exp-1 (0 if exp <= 1), result exp = 0.
  - Exponent arithmetic is done in C_EXP_PRENORM signed bits. An input exp of 0 is treated as effective exponent 1.
- Stage 2 (round and pack, registered):
  - Fields: G = bit22, S = |bits21:0, LSB = bit23.
  - Round-to-nearest-even: increment fraction when G && (S || LSB).
  - Rounding carry out of the hidden bit gives exp+1 and fraction 0. A subnormal that rounds to hidden=1 becomes exp 1.
  - inexact_o = G || S.
  - exp >= 255 after rounding: result = {sign, 8'hFF, 23'h0}, overflow_o = 1, inexact_o = 1.
- Simultaneous accept and drain in one cycle is legal and loses nothing.
- NaN and infinity inputs are not handled here; the wrapper bypasses them.

Decomposition:
- fp_defs gains:
  - C_LZC_W = 6.
  - Packed struct fp_status_t {overflow, inexact}.
  - Constants C_BIAS = 127 and C_EXP_MAX = 255.
- One sub-module: fp_lzc, a parameterized leading-zero counter (width 47, output C_LZC_W, plus an all-zero flag), used in stage 1.

Test Plan:
- exp=127, mant=48'h4000_0000_0000, out_ready_i=1 -> result_o=32'h3F80_0000, flags 0, out_valid_o exactly 2 cycles after accept.
- exp=127, mant=48'h8000_0000_0000 (carry) -> 32'h4000_0000; exp=127, mant=48'h0000_4000_0000 (lz=16) -> 32'h3780_0000.
- RNE: mant=bit46|bit22 -> 32'h3F80_0000, inexact=1; mant=bit46|bit23|bit22 -> 32'h3F80_0002, inexact=1.
- Overflow and zero: exp=254, mant bit47 -> 32'h7F80_0000, overflow=1, inexact=1; mant=0 with sign=1 -> 32'h0000_0000, flags 0.
- Backpressure: 4 back-to-back inputs with out_ready_i held low for 3 cycles.
  - in_ready_o drops after 2 accepts.
  - result_o stays stable while stalled.
  - All 4 results emerge in order with none dropped or duplicated.
- Reset with both stages full -> out_valid_o=0 next cycle, in_ready_o=1. The first post-reset input yields its correct result 2 cycles later.

Source files
------------

// File: rtl/fp_defs.sv
// Shared FP32 datapath constants and types for the adder / normalizer path.
package fp_defs;

  localparam int C_EXP          = 8;
  localparam int C_MANT         = 23;
  localparam int C_EXP_PRENORM  = 10;
  localparam int C_MANT_PRENORM = 48;
  localparam int C_LZC_W        = 6;
  localparam int C_BIAS         = 127;
  localparam int C_EXP_MAX      = 255;

  typedef struct packed {
    logic overflow;
    logic inexact;
  } fp_status_t;

  // Normalized value held between the normalize and round stages; the carry bit is gone.
  typedef struct packed {
    logic                              sign;
    logic                              zero;
    logic signed [C_EXP_PRENORM-1:0]   exp;
    logic        [C_MANT_PRENORM-2:0]  mant;
  } norm_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter, combinational; counts from the MSB, all_zero flags an empty word.
module fp_lzc
  import fp_defs::*;
#(
  parameter int WIDTH = 47,
  parameter int CNT_W = C_LZC_W
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt,
  output logic             all_zero
);

  logic found;

  always_comb begin
    cnt   = CNT_W'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && data[i]) begin
        cnt   = CNT_W'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

  assign all_zero = ~|data;

endmodule

// File: rtl/fp_norm_round.sv
// FP32 post-normalize and round-to-nearest-even, two registered stages (2-cycle latency, 1/cycle).
// Elastic valid/ready: each stage loads when its downstream is empty or draining; outputs hold while stalled.
module fp_norm_round
  import fp_defs::*;
(
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic                              sign_prenorm_i,
  input  logic signed [C_EXP_PRENORM-1:0]   exp_prenorm_i,
  input  logic        [C_MANT_PRENORM-1:0]  mant_prenorm_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic        [31:0]                result_o,
  output logic                              overflow_o,
  output logic                              inexact_o
);

  localparam logic signed [C_EXP_PRENORM-1:0] EXP_ONE = C_EXP_PRENORM'(1);
  localparam logic signed [C_EXP_PRENORM-1:0] EXP_TOP = C_EXP_PRENORM'(C_EXP_MAX);

  logic s1_vld, s2_vld, s2_free;
  norm_t s1_q, s1_d;
  fp_status_t status_q, status_d;
  logic [31:0] result_d;

  assign s2_free     = !s2_vld || out_ready_i;
  assign in_ready_o  = !s1_vld || s2_free;
  assign out_valid_o = s2_vld;
  assign overflow_o  = status_q.overflow;
  assign inexact_o   = status_q.inexact;

  // ---------------- stage 1: normalize ----------------
  logic [C_LZC_W-1:0]               lz, sh;
  logic                             lz_all_zero;
  logic signed [C_EXP_PRENORM-1:0]  exp_eff, lz_s, exp_lz_diff;

  fp_lzc #(
    .WIDTH (C_MANT_PRENORM - 1),
    .CNT_W (C_LZC_W)
  ) u_lzc (
    .data     (mant_prenorm_i[C_MANT_PRENORM-2:0]),
    .cnt      (lz),
    .all_zero (lz_all_zero)
  );

  always_comb begin
    // A zero exponent denotes subnormal operands, which share the scale of exponent 1.
    exp_eff     = (exp_prenorm_i < EXP_ONE) ? EXP_ONE : exp_prenorm_i;
    lz_s        = $signed({{(C_EXP_PRENORM-C_LZC_W){1'b0}}, lz});
    exp_lz_diff = exp_eff - lz_s;
    sh          = '0;
    s1_d        = '0;
    s1_d.sign   = sign_prenorm_i;
    s1_d.zero   = !mant_prenorm_i[C_MANT_PRENORM-1] && lz_all_zero;
    if (mant_prenorm_i[C_MANT_PRENORM-1]) begin
      s1_d.mant = {mant_prenorm_i[C_MANT_PRENORM-1:2], mant_prenorm_i[1] | mant_prenorm_i[0]};
      s1_d.exp  = exp_eff + EXP_ONE;
    end else if (exp_lz_diff >= EXP_ONE) begin
      sh        = lz;
      s1_d.mant = mant_prenorm_i[C_MANT_PRENORM-2:0] << sh;
      s1_d.exp  = exp_lz_diff;
    end else begin
      // Not enough exponent range to normalize fully: the result stays subnormal.
      sh        = C_LZC_W'(exp_eff - EXP_ONE);
      s1_d.mant = mant_prenorm_i[C_MANT_PRENORM-2:0] << sh;
      s1_d.exp  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
    end else if (in_ready_o) begin
      s1_vld <= in_valid_i;
      if (in_valid_i) s1_q <= s1_d;
    end
  end

  // ---------------- stage 2: round and pack ----------------
  logic                             g_bit, s_bit, lsb_bit, rnd_up, ovf;
  logic [C_MANT+1:0]                sum;
  logic signed [C_EXP_PRENORM-1:0]  r_exp;
  logic [C_MANT-1:0]                r_frac;

  always_comb begin
    g_bit   = s1_q.mant[C_MANT-1];
    s_bit   = |s1_q.mant[C_MANT-2:0];
    lsb_bit = s1_q.mant[C_MANT];
    rnd_up  = g_bit && (s_bit || lsb_bit);
    sum     = {1'b0, s1_q.mant[C_MANT_PRENORM-2:C_MANT]} + (C_MANT+2)'(rnd_up);
    if (sum[C_MANT+1]) begin
      r_exp  = s1_q.exp + EXP_ONE;
      r_frac = '0;
    end else begin
      // A subnormal that rounds up into the hidden bit becomes the smallest normal.
      r_exp  = (s1_q.exp == '0 && sum[C_MANT]) ? EXP_ONE : s1_q.exp;
      r_frac = sum[C_MANT-1:0];
    end
    ovf      = (r_exp >= EXP_TOP);
    result_d = '0;
    status_d = '0;
    if (s1_q.zero) begin
      result_d = '0;
      status_d = '0;
    end else if (ovf) begin
      result_d          = {s1_q.sign, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
      status_d.overflow = 1'b1;
      status_d.inexact  = 1'b1;
    end else begin
      result_d         = {s1_q.sign, r_exp[C_EXP-1:0], r_frac};
      status_d.inexact = g_bit || s_bit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_vld   <= 1'b0;
      result_o <= '0;
      status_q <= '0;
    end else if (s2_free) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        result_o <= result_d;
        status_q <= status_d;
      end
    end
  end

endmodule
